// File: rtl/activation_lut_fetch_pkg.sv
// ============================================================================
// Module      : activation_lut_fetch_pkg
// Description : Shared constants and types for the activation LUT fetch stage
//               and the downstream linear interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package activation_lut_fetch_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int FRAC_BITS   = 4;
  localparam int INT_BITS    = DATA_WIDTH - FRAC_BITS;
  // One extra sample so that the top interval still has a right-hand neighbour.
  localparam int TABLE_DEPTH = (2 ** INT_BITS) + 1;
  localparam int ADDR_WIDTH  = $clog2(TABLE_DEPTH);

  typedef logic signed [DATA_WIDTH-1:0] fixed_t;
  typedef logic        [ADDR_WIDTH-1:0] lut_addr_t;

  // Integer part of x converted to offset binary: inverting the sign bit of a
  // two's complement value is the same as adding 2**(INT_BITS-1).
  function automatic lut_addr_t x_to_addr(input logic [DATA_WIDTH-1:0] x);
    lut_addr_t a;
    a = '0;
    a[INT_BITS-1:0] = {~x[DATA_WIDTH-1], x[DATA_WIDTH-2:FRAC_BITS]};
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/activation_lut_fetch_sample_table.sv
// ============================================================================
// Module      : activation_sample_table
// Description : TABLE_DEPTH x DATA_WIDTH flop register file. One synchronous
//               write port, two combinational read ports (addr, addr+1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module activation_sample_table
  import activation_lut_fetch_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o
);

  localparam lut_addr_t LAST_ADDR = lut_addr_t'(TABLE_DEPTH - 1);

  fixed_t    mem_q [TABLE_DEPTH];
  lut_addr_t raddr1;

  assign raddr1 = raddr_i + lut_addr_t'(1);

  // Sample storage; writes to addresses beyond the table are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i <= LAST_ADDR)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports; the range guard only keeps the index legal, the fetch stage
  // never presents an address past TABLE_DEPTH-2.
  always_comb begin
    rdata0_o = '0;
    rdata1_o = '0;
    if (raddr_i <= LAST_ADDR) rdata0_o = mem_q[raddr_i];
    if (raddr1  <= LAST_ADDR) rdata1_o = mem_q[raddr1];
  end

endmodule

`default_nettype wire

// File: rtl/activation_lut_fetch.sv
// ============================================================================
// Module      : activation_lut_fetch
// Description : Splits a fixed-point pre-activation into table index and
//               fraction, fetches the bracketing samples and presents
//               base / next / change / remaining to the interpolator.
//               Two-stage pipeline, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module activation_lut_fetch
  import activation_lut_fetch_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_we_i,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] x_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] base_o,
  output logic [DATA_WIDTH-1:0] next_data_o,
  output logic [DATA_WIDTH-1:0] change_o,
  output logic [DATA_WIDTH-1:0] remaining_o
);

  logic                 en;
  logic                 s1_valid_q, s1_valid_d;
  lut_addr_t            s1_addr_q,  s1_addr_d;
  logic [FRAC_BITS-1:0] s1_rem_q,   s1_rem_d;
  logic                 out_valid_q, out_valid_d;
  fixed_t               base_q,   base_d;
  fixed_t               next_q,   next_d;
  fixed_t               change_q, change_d;
  fixed_t               rem_q,    rem_d;
  fixed_t               rd0, rd1;

  // The whole pipeline moves as one; a stalled output freezes both stages.
  assign en         = !out_valid_q || out_ready_i;
  assign in_ready_o = en;

  activation_sample_table u_table (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (cfg_we_i),
    .waddr_i  (cfg_addr_i),
    .wdata_i  (cfg_data_i),
    .raddr_i  (s1_addr_q),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

  // Next-state for both stages; stage-2 data only reloads on a valid beat.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_addr_d   = s1_addr_q;
    s1_rem_d    = s1_rem_q;
    out_valid_d = out_valid_q;
    base_d      = base_q;
    next_d      = next_q;
    change_d    = change_q;
    rem_d       = rem_q;
    if (en) begin
      s1_valid_d  = in_valid_i;
      s1_addr_d   = x_to_addr(x_in_i);
      s1_rem_d    = x_in_i[FRAC_BITS-1:0];
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        base_d   = rd0;
        next_d   = rd1;
        change_d = rd1 - rd0;
        rem_d    = {{INT_BITS{1'b0}}, s1_rem_q};
      end
    end
  end

  // Pipeline registers; reset discards any in-flight beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_rem_q    <= '0;
      out_valid_q <= 1'b0;
      base_q      <= '0;
      next_q      <= '0;
      change_q    <= '0;
      rem_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_rem_q    <= s1_rem_d;
      out_valid_q <= out_valid_d;
      base_q      <= base_d;
      next_q      <= next_d;
      change_q    <= change_d;
      rem_q       <= rem_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign base_o      = base_q;
  assign next_data_o = next_q;
  assign change_o    = change_q;
  assign remaining_o = rem_q;

endmodule

`default_nettype wire
